// File: rtl/video_pattern_src_if.sv
// Pixel stream bundle between the synthetic video source and the filter chain.
//   frame_vsync : frame valid, high across every active line including its blanking
//   frame_href  : line valid, high on active pixel ticks only
//   frame_clken : pixel tick strobe, one clk wide
//   pix_y       : 8-bit luma, non-zero only when frame_href & frame_clken
// master = source side (drives the stream), slave = consumer side.
interface video_pattern_src_if;
    logic       frame_vsync;
    logic       frame_href;
    logic       frame_clken;
    logic [7:0] pix_y;

    modport master (output frame_vsync, frame_href, frame_clken, pix_y);
    modport slave  (input  frame_vsync, frame_href, frame_clken, pix_y);
endinterface

// File: rtl/video_pattern_src.sv
// Synthetic video source: frame timing with blanking plus one of four 8-bit luma
// test patterns (h-ramp, v-ramp, checker, seeded impulse noise). Stands in for the
// CMOS capture front-end during bring-up and filter regression.
// Ports:
//   clk, rst_n  : pixel-domain clock, asynchronous active-low reset
//   enable      : run request, only looked at on frame boundaries
//   pattern     : 0 h-ramp, 1 v-ramp, 2 checker, 3 impulse noise (latched per frame)
//   vid         : pixel stream (vsync/href/clken/y), master side
//   busy        : high whenever the sequencer is not idle
//   frame_done  : one-clk pulse on the last tick of the post-frame blanking
//
// state    | meaning
// S_IDLE   | waiting for enable on a pixel tick
// S_VPRE   | V_PRE blank lines ahead of the picture
// S_ACTIVE | active pixels of an active line (href high)
// S_HBLANK | H_BLANK ticks closing an active line
// S_VPOST  | V_POST blank lines after the picture
module video_pattern_src #(
    parameter int IMG_HDISP = 320,
    parameter int IMG_VDISP = 240,
    parameter int H_BLANK   = 40,
    parameter int V_PRE     = 2,
    parameter int V_POST    = 2,
    parameter int CLK_DIV   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 pattern,
    video_pattern_src_if.master        vid,
    output logic                       busy,
    output logic                       frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_VPRE, S_ACTIVE, S_HBLANK, S_VPOST} state_t;

    localparam logic [4:0]  DIV_LAST   = 5'(CLK_DIV - 1);
    localparam logic [15:0] LINE_LAST  = 16'(IMG_HDISP + H_BLANK - 1);
    localparam logic [15:0] HDISP_LAST = 16'(IMG_HDISP - 1);
    localparam logic [15:0] VDISP_LAST = 16'(IMG_VDISP - 1);
    localparam logic [15:0] VPRE_LAST  = 16'(V_PRE - 1);
    localparam logic [15:0] VPOST_LAST = 16'(V_POST - 1);
    localparam logic [15:0] LFSR_SEED  = 16'hACE1;

    state_t      state, state_d, state_eff;
    logic [4:0]  div_cnt;
    logic        tick;
    logic [15:0] x, x_d, x_wrap, row, row_d;
    logic [1:0]  pat_r, pat_d;
    logic [15:0] lfsr, lfsr_d, lfsr_step;
    logic        line_end;
    logic        vsync_d, href_d, done_d;
    logic [7:0]  y_d, pix_val;
    logic        vsync_q, href_q, clken_q, done_q;
    logic [7:0]  y_q;

    assign tick      = (div_cnt == DIV_LAST);
    assign lfsr_step = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            x       <= '0;
            row     <= '0;
            pat_r   <= '0;
            lfsr    <= LFSR_SEED;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            y_q     <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            div_cnt <= tick ? 5'd0 : div_cnt + 5'd1;
            // Stream outputs are registered together so they stay cycle-aligned;
            // href/y/done only ever appear alongside clken.
            clken_q <= tick;
            href_q  <= tick & href_d;
            y_q     <= tick ? y_d : 8'h00;
            done_q  <= tick & done_d;
            if (tick) begin
                state   <= state_d;
                x       <= x_d;
                row     <= row_d;
                pat_r   <= pat_d;
                lfsr    <= lfsr_d;
                vsync_q <= vsync_d;
            end
        end
    end

    always_comb begin
        pix_val = 8'h00;
        unique case (pat_r)
            2'd0: pix_val = x[7:0];
            2'd1: pix_val = row[7:0];
            2'd2: pix_val = (x[3] ^ row[3]) ? 8'hFF : 8'h00;
            default: begin
                if (lfsr[3:0] == 4'd0)      pix_val = 8'hFF;
                else if (lfsr[3:0] == 4'd1) pix_val = 8'h00;
                else                        pix_val = 8'h80;
            end
        endcase
    end

    always_comb begin
        // The enabling tick in IDLE is already tick 0 of the pre-blank.
        state_eff = state;
        if (state == S_IDLE && enable) state_eff = S_VPRE;
        state_d  = state_eff;
        x_d      = x;
        row_d    = row;
        pat_d    = pat_r;
        lfsr_d   = lfsr;
        vsync_d  = 1'b0;
        href_d   = 1'b0;
        y_d      = 8'h00;
        done_d   = 1'b0;
        line_end = (x == LINE_LAST);
        x_wrap   = line_end ? 16'd0 : x + 16'd1;
        unique case (state_eff)
            S_IDLE: begin
                x_d   = '0;
                row_d = '0;
            end
            S_VPRE: begin
                if (state == S_IDLE) begin
                    pat_d  = pattern;
                    lfsr_d = LFSR_SEED;
                end
                x_d = x_wrap;
                if (line_end) begin
                    if (row == VPRE_LAST) begin
                        row_d   = '0;
                        state_d = S_ACTIVE;
                    end else begin
                        row_d = row + 16'd1;
                    end
                end
            end
            S_ACTIVE: begin
                vsync_d = 1'b1;
                href_d  = 1'b1;
                y_d     = pix_val;
                lfsr_d  = lfsr_step;
                x_d     = x + 16'd1;
                if (x == HDISP_LAST) state_d = S_HBLANK;
            end
            S_HBLANK: begin
                vsync_d = 1'b1;
                x_d     = x_wrap;
                if (line_end) begin
                    if (row == VDISP_LAST) begin
                        row_d   = '0;
                        state_d = S_VPOST;
                    end else begin
                        row_d   = row + 16'd1;
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_VPOST: begin
                x_d = x_wrap;
                if (line_end) begin
                    if (row == VPOST_LAST) begin
                        row_d  = '0;
                        done_d = 1'b1;
                        // Back-to-back frames: the next pre-blank starts on the very next tick.
                        if (enable) begin
                            state_d = S_VPRE;
                            pat_d   = pattern;
                            lfsr_d  = LFSR_SEED;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        row_d = row + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign vid.frame_vsync = vsync_q;
    assign vid.frame_href  = href_q;
    assign vid.frame_clken = clken_q;
    assign vid.pix_y       = y_q;
    assign busy            = (state != S_IDLE);
    assign frame_done      = done_q;
endmodule

// File: tb/tb_video_pattern_src.sv
module tb_video_pattern_src;
    localparam int HD = 8, VD = 4, HB = 4, VPRE = 1, VPOST = 1, CD = 2;
    localparam int LINE = HD + HB;
    localparam int FRAME = (VPRE + VD + VPOST) * LINE;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       en16 = 1'b0;
    logic [1:0] pattern = 2'd0;
    logic [1:0] pat16 = 2'd2;
    logic       busy, frame_done, busy16, done16;

    video_pattern_src_if vif ();
    video_pattern_src_if vif16 ();

    video_pattern_src #(.IMG_HDISP(HD), .IMG_VDISP(VD), .H_BLANK(HB),
                        .V_PRE(VPRE), .V_POST(VPOST), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern(pattern),
        .vid(vif), .busy(busy), .frame_done(frame_done));

    video_pattern_src #(.IMG_HDISP(16), .IMG_VDISP(10), .H_BLANK(2),
                        .V_PRE(1), .V_POST(1), .CLK_DIV(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .enable(en16), .pattern(pat16),
        .vid(vif16), .busy(busy16), .frame_done(done16));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: frame position as a plain tick index, everything else derived arithmetically.
    int          m_div = 0, m_f = 0, m_line, m_col, m_r;
    bit          m_run = 0;
    logic [1:0]  m_pat = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic        e_vs = 0, e_hr = 0, e_ck = 0, e_done = 0, e_busy = 0;
    logic [7:0]  e_y = 0;

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {v[14:0], ^(v & 16'hB400)};
    endfunction

    function automatic logic [7:0] noise_y(input logic [15:0] v);
        case (v % 16)
            0: return 8'hFF;
            1: return 8'h00;
            default: return 8'h80;
        endcase
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_div = 0; m_run = 0; m_f = 0;
                e_vs = 0; e_hr = 0; e_ck = 0; e_y = 0; e_done = 0; e_busy = 0;
            end else begin
                e_ck = 0; e_hr = 0; e_y = 0; e_done = 0;
                if (m_div == CD - 1) begin
                    m_div = 0;
                    e_ck = 1;
                    if (!m_run && enable) begin
                        m_run = 1; m_f = 0; m_pat = pattern; m_lfsr = 16'hACE1;
                    end
                    if (m_run) begin
                        m_line = m_f / LINE;
                        m_col  = m_f % LINE;
                        e_vs = (m_line >= VPRE) && (m_line < VPRE + VD);
                        if (e_vs && m_col < HD) begin
                            e_hr = 1;
                            m_r = m_line - VPRE;
                            case (m_pat)
                                2'd0: e_y = 8'(m_col % 256);
                                2'd1: e_y = 8'(m_r % 256);
                                2'd2: e_y = (((m_col / 8) + (m_r / 8)) % 2 == 1) ? 8'hFF : 8'h00;
                                default: begin
                                    e_y = noise_y(m_lfsr);
                                    m_lfsr = lfsr_adv(m_lfsr);
                                end
                            endcase
                        end
                        if (m_f == FRAME - 1) begin
                            e_done = 1;
                            m_f = 0;
                            if (enable) begin
                                m_pat = pattern; m_lfsr = 16'hACE1;
                            end else begin
                                m_run = 0;
                            end
                        end else begin
                            m_f++;
                        end
                    end else begin
                        e_vs = 0;
                    end
                end else begin
                    m_div++;
                end
                e_busy = m_run;
            end
        end
    end

    // Monitor: full stream comparison every cycle plus counters for the directed checks.
    int          cyc = 0, cnt_ck, cnt_href, cnt_vs, cnt_done, cnt_busy, ysum, bad_y;
    int          t_start, t_href, t_done;
    logic [7:0]  px_log [64];
    logic        busy_prev = 0;
    int          p16 = 0, p16_last = 0, n16_frames = 0;
    logic [12:0] got_v, exp_v;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            got_v = {vif.frame_vsync, vif.frame_href, vif.frame_clken, vif.pix_y, busy, frame_done};
            exp_v = {e_vs, e_hr, e_ck, e_y, e_busy, e_done};
            check("stream", got_v, exp_v);
            if (vif.frame_clken) cnt_ck++;
            if (busy) cnt_busy++;
            if (vif.frame_clken && vif.frame_vsync) cnt_vs++;
            if (vif.frame_href && vif.frame_clken) begin
                if (t_href < 0) t_href = cyc;
                if (cnt_href < 64) px_log[cnt_href] = vif.pix_y;
                if (vif.pix_y != 8'h00 && vif.pix_y != 8'h80 && vif.pix_y != 8'hFF) bad_y++;
                ysum += int'(vif.pix_y);
                cnt_href++;
            end
            if (busy && !busy_prev && t_start < 0) t_start = cyc;
            busy_prev = busy;
            if (frame_done) begin
                if (t_done < 0) t_done = cyc;
                cnt_done++;
            end
            if (vif16.frame_href && vif16.frame_clken) begin
                check("checker16_px", vif16.pix_y,
                      ((((p16 % 16) / 8) + ((p16 / 16) / 8)) % 2 == 1) ? 8'hFF : 8'h00);
                p16++;
            end
            if (done16) begin
                n16_frames++; p16_last = p16; p16 = 0;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic clear_counts();
        cnt_ck = 0; cnt_href = 0; cnt_vs = 0; cnt_done = 0; cnt_busy = 0;
        ysum = 0; bad_y = 0; t_start = -1; t_href = -1; t_done = -1;
    endtask

    task automatic wait_done(input int n, input string name);
        int k = 0;
        while (cnt_done < n && k < 400) begin step(); k++; end
        check(name, (cnt_done >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_busy(input string name);
        int k = 0;
        while (!busy && k < 20) begin step(); k++; end
        check(name, busy, 1);
    endtask

    typedef struct {
        logic [1:0] pat;
        int         frames;
        int         exp_href;
        int         exp_ysum;   // -1: not summed (noise pattern)
        int         exp_vs;
    } row_t;
    row_t rows[4];

    initial begin
        int diffs, k;
        rows[0] = '{2'd0, 1, 32, 112, 48};
        rows[1] = '{2'd1, 2, 64, 96, 96};
        rows[2] = '{2'd2, 1, 32, 0, 48};
        rows[3] = '{2'd3, 2, 64, -1, 96};

        repeat (3) step();
        check("reset_outputs",
              {vif.frame_vsync, vif.frame_href, vif.frame_clken, vif.pix_y, busy, frame_done}, 0);
        rst_n = 1'b1;

        clear_counts();
        repeat (20) step();
        check("idle_clken_count", cnt_ck, 10);
        check("idle_done_count", cnt_done, 0);
        check("idle_busy_cycles", cnt_busy, 0);
        check("idle_vsync_ticks", cnt_vs, 0);

        for (int i = 0; i < 4; i++) begin
            clear_counts();
            pattern = rows[i].pat;
            enable = 1'b1;
            wait_busy("row_start");
            if (rows[i].frames == 1) enable = 1'b0;
            wait_done(1, "row_done1");
            enable = 1'b0;
            if (rows[i].frames == 2) wait_done(2, "row_done2");
            repeat (4) step();
            check("row_frames", cnt_done, rows[i].frames);
            check("row_href_ticks", cnt_href, rows[i].exp_href);
            check("row_vsync_ticks", cnt_vs, rows[i].exp_vs);
            check("row_busy_end", busy, 0);
            if (rows[i].exp_ysum >= 0) check("row_ysum", ysum, rows[i].exp_ysum);
            if (i == 0) begin
                check("first_href_latency", t_href - t_start, 12 * CD);
                check("frame_done_latency", t_done - t_start, (FRAME - 1) * CD);
            end
            if (rows[i].pat == 2'd3) begin
                check("noise_levels", bad_y, 0);
                diffs = 0;
                for (int j = 0; j < 32; j++) if (px_log[j] !== px_log[j + 32]) diffs++;
                check("noise_repeat", diffs, 0);
            end
        end

        // Checker pattern on the 16-wide instance, enable dropped right after start.
        en16 = 1'b1;
        k = 0;
        while (!busy16 && k < 10) begin step(); k++; end
        check("chk16_start", busy16, 1);
        en16 = 1'b0;
        k = 0;
        while (n16_frames < 1 && k < 400) begin step(); k++; end
        check("chk16_frames", n16_frames, 1);
        check("chk16_pixels", p16_last, 160);

        // Enable dropped and pattern changed mid-ACTIVE: frame completes as pattern 0.
        clear_counts();
        pattern = 2'd0;
        enable = 1'b1;
        k = 0;
        while (!vif.frame_vsync && k < 100) begin step(); k++; end
        check("mid_vsync_seen", vif.frame_vsync, 1);
        enable = 1'b0;
        pattern = 2'd1;
        wait_done(1, "mid_done");
        repeat (10) step();
        check("mid_ysum", ysum, 112);
        check("mid_href_ticks", cnt_href, 32);
        check("mid_vsync_ticks", cnt_vs, 48);
        check("mid_busy_after", busy, 0);
        check("mid_frames", cnt_done, 1);

        // Asynchronous reset in the middle of the active region.
        pattern = 2'd0;
        enable = 1'b1;
        k = 0;
        while (!vif.frame_vsync && k < 100) begin step(); k++; end
        check("rst_vsync_seen", vif.frame_vsync, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset",
              {vif.frame_vsync, vif.frame_href, vif.frame_clken, vif.pix_y, busy, frame_done}, 0);
        step();
        enable = 1'b0;
        step();
        rst_n = 1'b1;

        // Random enable/pattern/reset activity against the reference model.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 9) == 0) pattern = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 799) == 0) begin
                rst_n = 1'b0;
                step();
                rst_n = 1'b1;
            end
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
